// File: rtl/bitplane_serializer_pkg.sv
// Shared types and helpers for the bit-plane serializer.
// Optional feature macro: PARITY_EN (appends an even-parity bit to every frame).
package bitplane_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

`ifdef PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Plane-index field, one bit per word, then the optional parity bit.
    function automatic int frame_len(input int plane_w, input int words);
        return plane_w + words + PARITY_BITS;
    endfunction

endpackage

// File: rtl/bitplane_serializer_if.sv
// Handshake and register-bank bus of the bit-plane serializer.
interface bitplane_serializer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) ();

    logic              start;
    logic              busy;
    logic              done;
    logic              rb_rw;
    logic [ADDR_W-1:0] rb_a;
    logic [DATA_W-1:0] rb_d;
    logic [DATA_W-1:0] rb_q;
    logic              sen;
    logic              sd;

    modport master (
        input  start,
        input  rb_q,
        output busy,
        output done,
        output rb_rw,
        output rb_a,
        output rb_d,
        output sen,
        output sd
    );

    modport slave (
        output start,
        output rb_q,
        input  busy,
        input  done,
        input  rb_rw,
        input  rb_a,
        input  rb_d,
        input  sen,
        input  sd
    );

endinterface

// File: rtl/bitplane_serializer_frame_tx.sv
// Frame shifter: loads plane index and captured bits, shifts them out MSB first on sen/sd.
// Optional feature macro: PARITY_EN (appends even parity over index and data bits).
module bitplane_frame_tx
    import bitplane_pkg::*;
#(
    parameter int WORDS   = 18,
    parameter int PLANE_W = 3,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane_in,
    input  logic [WORDS-1:0]   data_in,
    output logic               sen,
    output logic               sd,
    output logic               tx_last
);

    localparam int FRAME_LEN = frame_len(PLANE_W, WORDS);

    logic [FRAME_LEN-1:0] frame;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic                 active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
`ifdef PARITY_EN
        frame = {plane_in, data_in, ^{plane_in, data_in}};
`else
        frame = {plane_in, data_in};
`endif
        tx_last  = active_q && (cnt_q == CNT_W'(FRAME_LEN - 1));
        shift_d  = shift_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        if (load) begin
            shift_d  = frame;
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (tx_last) begin
                shift_d  = '0;
                active_d = 1'b0;
                cnt_d    = '0;
            end
        end
        sen = ~active_q;
        sd  = active_q & shift_q[FRAME_LEN-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/bitplane_serializer.sv
// Reads WORDS register-bank words, transposes them into DATA_W bit-planes and sends one serial frame per plane.
// Optional feature macro: PARITY_EN (handled inside bitplane_frame_tx).
module bitplane_serializer
    import bitplane_pkg::*;
#(
    parameter int WORDS  = 18,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bitplane_serializer_if.master bus
);

    localparam int PLANE_W = clog2(DATA_W);
    localparam int CNT_W   = clog2(WORDS + PLANE_W + 2);

    state_t             state_q, state_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  rb_a_q, rb_a_d;
    logic [WORDS-1:0]   cap_q, cap_d;
    logic               plane_bit;
    logic               tx_load;
    logic               tx_last;

    // Plane 0 is the MSB of each word.
    always_comb begin
        plane_bit = 1'b0;
        for (int j = 0; j < DATA_W; j++) begin
            if (plane_q == PLANE_W'(j)) begin
                plane_bit = bus.rb_q[DATA_W-1-j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        cnt_d   = cnt_q;
        rb_a_d  = '0;
        cap_d   = cap_q;
        tx_load = 1'b0;

        // rb_q lags rb_a by one cycle, so READ cycle k+1 captures word k.
        for (int k = 0; k < WORDS; k++) begin
            if (state_q == READ && cnt_q == CNT_W'(k + 1)) begin
                cap_d[k] = plane_bit;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    plane_d = '0;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (cnt_q == CNT_W'(WORDS)) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    tx_load = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q < CNT_W'(WORDS - 1)) begin
                        rb_a_d = rb_a_q + ADDR_W'(1);
                    end else begin
                        rb_a_d = rb_a_q;
                    end
                end
            end
            SEND: begin
                if (tx_last) begin
                    if (plane_q == PLANE_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        plane_d = plane_q + PLANE_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = READ;
                    plane_d = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            plane_q <= '0;
            cnt_q   <= '0;
            rb_a_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            cnt_q   <= cnt_d;
            rb_a_q  <= rb_a_d;
            cap_q   <= cap_d;
        end
    end

    // The last word arrives in the loading cycle, so the shifter takes cap_d rather than cap_q.
    bitplane_frame_tx #(
        .WORDS   (WORDS),
        .PLANE_W (PLANE_W),
        .CNT_W   (CNT_W)
    ) u_frame_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .plane_in (plane_q),
        .data_in  (cap_d),
        .sen      (bus.sen),
        .sd       (bus.sd),
        .tx_last  (tx_last)
    );

    always_comb begin
        bus.busy  = (state_q == READ) || (state_q == SEND);
        bus.done  = (state_q == DONE);
        bus.rb_rw = 1'b1;
        bus.rb_d  = '0;
        bus.rb_a  = rb_a_q;
    end

endmodule

// File: tb/tb_bitplane_serializer.sv
// Self-checking bench for bitplane_serializer: default geometry and a 4x2 geometry, cycle-checked
// against a frame model computed from the plane/word layout. Honours PARITY_EN when defined.
module tb_bitplane_serializer;
    import bitplane_pkg::*;

    localparam int WA = 18, DA = 8, AA = 5;
    localparam int WB = 4,  DB = 2, AB = 2;
    localparam int PWA = 3, PWB = 1;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int TA = 8 * (19 + 21 + PAR);
    localparam int TB = 2 * (5 + 5 + PAR);

    typedef struct {
        string name;
        int    sel;
        int    fill;
        int    poke1;
        int    poke2;
        bit    chain;
        int    total;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem_a [0:31];
    logic [15:0] mem_b [0:3];

    always #5 clk = ~clk;

    bitplane_serializer_if #(.DATA_W(DA), .ADDR_W(AA)) bus_a ();
    bitplane_serializer_if #(.DATA_W(DB), .ADDR_W(AB)) bus_b ();

    bitplane_serializer #(.WORDS(WA), .DATA_W(DA), .ADDR_W(AA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    bitplane_serializer #(.WORDS(WB), .DATA_W(DB), .ADDR_W(AB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Synchronous single-port register bank: data appears the cycle after the address.
    always @(posedge clk) begin
        bus_a.rb_q <= mem_a[bus_a.rb_a][DA-1:0];
        bus_b.rb_q <= mem_b[bus_b.rb_a][DB-1:0];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected, input int t);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h", name, t, actual, expected);
        end
    endtask

    function automatic int dataBit(input int sel, input int p, input int k);
        logic [15:0] w;
        if (sel == 0) begin
            w = mem_a[k];
            return int'(w[DA-1-p]);
        end
        w = mem_b[k];
        return int'(w[DB-1-p]);
    endfunction

    // Bit b of frame p: index MSB first, then words W-1..0, then even parity.
    function automatic int frameBit(input int sel, input int p, input int b);
        int w  = (sel == 0) ? WA : WB;
        int pw = (sel == 0) ? PWA : PWB;
        int par = 0;
        if (b < pw) return (p >> (pw - 1 - b)) & 1;
        if (b < pw + w) return dataBit(sel, p, w - 1 - (b - pw));
        for (int i = 0; i < pw; i++) par ^= (p >> i) & 1;
        for (int k = 0; k < w; k++) par ^= dataBit(sel, p, k);
        return par;
    endfunction

    task automatic fillMem(input int sel, input int fill);
        int w = (sel == 0) ? WA : WB;
        for (int k = 0; k < 32; k++) begin
            logic [15:0] val;
            case (fill)
                0:       val = 16'(k + 1);
                1:       val = 16'hFFFF;
                default: val = 16'($urandom);
            endcase
            if (k >= w) val = 16'hA5A5;
            if (sel == 0) mem_a[k] = val;
            else if (k < 4) mem_b[k] = val;
        end
    endtask

    task automatic applyStimulus(input int sel, input logic val);
        if (sel == 0) bus_a.start = val;
        else bus_b.start = val;
    endtask

    task automatic sampleDut(input int sel, output logic s_sen, output logic s_sd,
                             output logic s_busy, output logic s_done,
                             output logic s_rw, output logic [31:0] s_rba);
        if (sel == 0) begin
            s_sen = bus_a.sen; s_sd = bus_a.sd; s_busy = bus_a.busy;
            s_done = bus_a.done; s_rw = bus_a.rb_rw; s_rba = 32'(bus_a.rb_a);
        end else begin
            s_sen = bus_b.sen; s_sd = bus_b.sd; s_busy = bus_b.busy;
            s_done = bus_b.done; s_rw = bus_b.rb_rw; s_rba = 32'(bus_b.rb_a);
        end
    endtask

    // One full job, compared every cycle; t=0 is the first cycle after start is sampled.
    task automatic runJob(input vec_t v);
        int w  = (v.sel == 0) ? WA : WB;
        int pw = (v.sel == 0) ? PWA : PWB;
        int r  = w + 1;
        int p  = r + pw + w + PAR;
        int len = v.chain ? 2 * v.total + 3 : v.total + 3;
        int tm, e_sen, e_busy, e_done, e_rba, e_sd;
        logic s_sen, s_sd, s_busy, s_done, s_rw;
        logic [31:0] s_rba;
        fillMem(v.sel, v.fill);
        $display("[TB] job %s", v.name);
        @(negedge clk);
        applyStimulus(v.sel, 1'b1);
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            sampleDut(v.sel, s_sen, s_sd, s_busy, s_done, s_rw, s_rba);
            tm = (v.chain && t > v.total) ? t - v.total - 1 : t;
            e_busy = 0; e_done = 0; e_sen = 1; e_rba = -1; e_sd = -1;
            if (tm < v.total) begin
                e_busy = 1;
                if (tm % p < r) begin
                    if (tm % p < w) e_rba = tm % p;
                end else begin
                    e_sen = 0;
                    e_sd = frameBit(v.sel, tm / p, tm % p - r);
                end
            end else if (tm == v.total) begin
                e_done = 1;
            end
            checkOutput({v.name, ".sen"}, 32'(s_sen), 32'(e_sen), t);
            checkOutput({v.name, ".busy"}, 32'(s_busy), 32'(e_busy), t);
            checkOutput({v.name, ".done"}, 32'(s_done), 32'(e_done), t);
            checkOutput({v.name, ".rb_rw"}, 32'(s_rw), 32'd1, t);
            checkOutput({v.name, ".rb_a_range"}, (s_rba < 32'(w)) ? 32'd1 : 32'd0, 32'd1, t);
            if (e_sd >= 0) checkOutput({v.name, ".sd"}, 32'(s_sd), 32'(e_sd), t);
            if (e_rba >= 0) checkOutput({v.name, ".rb_a"}, s_rba, 32'(e_rba), t);
            applyStimulus(v.sel, (t == v.poke1) || (t == v.poke2) || (v.chain && t == v.total));
        end
        applyStimulus(v.sel, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".a.sen"}, 32'(bus_a.sen), 32'd1, 0);
        checkOutput({tag, ".a.sd"}, 32'(bus_a.sd), 32'd0, 0);
        checkOutput({tag, ".a.busy"}, 32'(bus_a.busy), 32'd0, 0);
        checkOutput({tag, ".a.done"}, 32'(bus_a.done), 32'd0, 0);
        checkOutput({tag, ".a.rb_a"}, 32'(bus_a.rb_a), 32'd0, 0);
        checkOutput({tag, ".a.rb_rw"}, 32'(bus_a.rb_rw), 32'd1, 0);
        checkOutput({tag, ".a.rb_d"}, 32'(bus_a.rb_d), 32'd0, 0);
        checkOutput({tag, ".b.sen"}, 32'(bus_b.sen), 32'd1, 0);
        checkOutput({tag, ".b.sd"}, 32'(bus_b.sd), 32'd0, 0);
        checkOutput({tag, ".b.busy"}, 32'(bus_b.busy), 32'd0, 0);
        checkOutput({tag, ".b.rb_a"}, 32'(bus_b.rb_a), 32'd0, 0);
        checkOutput({tag, ".b.rb_d"}, 32'(bus_b.rb_d), 32'd0, 0);
    endtask

    vec_t tbl [8];

    initial begin
        int target;
        vec_t rv;
        tbl[0] = '{"a_count", 0, 0, -1, -1, 1'b0, TA};
        tbl[1] = '{"a_pokes", 0, 0,  5, 30, 1'b0, TA};
        tbl[2] = '{"a_ones",  0, 1, -1, -1, 1'b0, TA};
        tbl[3] = '{"a_rand",  0, 2, -1, -1, 1'b0, TA};
        tbl[4] = '{"a_chain", 0, 2, -1, -1, 1'b1, TA};
        tbl[5] = '{"b_count", 1, 0, -1, -1, 1'b0, TB};
        tbl[6] = '{"b_rand",  1, 2, -1, -1, 1'b0, TB};
        tbl[7] = '{"b_chain", 1, 1, -1, -1, 1'b1, TB};

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        fillMem(0, 0);
        fillMem(1, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) runJob(tbl[i]);

        // Reset in the middle of frame 3, bit 10, then a clean restart.
        $display("[TB] mid-frame reset");
        fillMem(0, 0);
        @(negedge clk);
        applyStimulus(0, 1'b1);
        target = 3 * (19 + 21 + PAR) + 19 + 10;
        for (int t = 0; t <= target; t++) begin
            @(negedge clk);
            applyStimulus(0, 1'b0);
        end
        checkOutput("abort.pre_sen", 32'(bus_a.sen), 32'd0, target);
        checkOutput("abort.pre_sd", 32'(bus_a.sd), 32'(frameBit(0, 3, 10)), target);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.sen", 32'(bus_a.sen), 32'd1, target);
        checkOutput("abort.sd", 32'(bus_a.sd), 32'd0, target);
        checkOutput("abort.busy", 32'(bus_a.busy), 32'd0, target);
        checkOutput("abort.done", 32'(bus_a.done), 32'd0, target);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checkOutput("abort.hold_done", 32'(bus_a.done), 32'd0, t);
            checkOutput("abort.hold_sen", 32'(bus_a.sen), 32'd1, t);
        end
        rst_n = 1'b1;
        @(negedge clk);
        rv = '{"a_restart", 0, 0, -1, -1, 1'b0, TA};
        runJob(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
